// File: rtl/rsm_pkg.sv
// Shared Simple RISC Machine definitions: memory commands, opcodes, nsel selects, widths.
package rsm_pkg;

    localparam int unsigned RSM_DATA_W = 16;
    localparam int unsigned RSM_PC_W   = 9;
    localparam int unsigned RSM_MEM_AW = 8;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [2:0] NSEL_RN = 3'b100;
    localparam logic [2:0] NSEL_RD = 3'b010;
    localparam logic [2:0] NSEL_RM = 3'b001;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Memory-side bus of the fetch/decode unit: address, read/write strobes and read data.
interface fetch_decode_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 9
);
    logic [PC_W-1:0]   mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mdata;

    modport master (output mem_addr, output mem_rd_en, output mem_wr_en, input mdata);
    modport slave  (input mem_addr, input mem_rd_en, input mem_wr_en, output mdata);
endinterface

// File: rtl/fetch_decode_unit_instr_decoder.sv
// Combinational IR decode: opcode/op fields, register number from nsel, shift, immediates.
module instr_decoder
    import rsm_pkg::*;
#(
    parameter int unsigned DATA_W = RSM_DATA_W
) (
    input  logic [DATA_W-1:0] i_ir,
    input  logic [2:0]        i_nsel,
    output logic [2:0]        o_opcode_c,
    output logic [1:0]        o_op_c,
    output logic [2:0]        o_readnum_c,
    output logic [1:0]        o_shift_c,
    output logic [DATA_W-1:0] o_sximm5_c,
    output logic [DATA_W-1:0] o_sximm8_c
);

    // Field extraction, register select and shift suppression for memory ops
    always_comb begin
        o_opcode_c  = i_ir[15:13];
        o_op_c      = i_ir[12:11];
        o_readnum_c = 3'b000;
        o_shift_c   = i_ir[4:3];
        o_sximm5_c  = {{(DATA_W-5){i_ir[4]}}, i_ir[4:0]};
        o_sximm8_c  = {{(DATA_W-8){i_ir[7]}}, i_ir[7:0]};

        case (i_nsel)
            NSEL_RN: o_readnum_c = i_ir[10:8];
            NSEL_RD: o_readnum_c = i_ir[7:5];
            NSEL_RM: o_readnum_c = i_ir[2:0];
            default: o_readnum_c = 3'b000;
        endcase

        if ((i_ir[15:13] == OPC_LDR) || (i_ir[15:13] == OPC_STR)) begin
            o_shift_c = 2'b00;
        end
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// Front end of the Simple RISC Machine: PC, data-address register, IR, memory gating, decode.
// Optional build macro FDU_INSTR_COUNT_EN adds a 16-bit instr_count output (load_ir edges).
module fetch_decode_unit
    import rsm_pkg::*;
#(
    parameter int unsigned DATA_W = RSM_DATA_W,
    parameter int unsigned PC_W   = RSM_PC_W,
    parameter int unsigned MEM_AW = RSM_MEM_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_ir,
    input  logic                load_pc,
    input  logic                reset_pc,
    input  logic                addr_sel,
    input  logic                load_addr,
    input  logic [1:0]          mem_cmd,
    input  logic [2:0]          nsel,
    input  logic [DATA_W-1:0]   datapath_out,
    fetch_decode_unit_if.master mem,
    output logic [2:0]          opcode,
    output logic [1:0]          op,
    output logic [2:0]          readnum,
    output logic [2:0]          writenum,
    output logic [1:0]          shift,
    output logic [DATA_W-1:0]   sximm5,
    output logic [DATA_W-1:0]   sximm8,
    output logic [PC_W-1:0]     pc,
`ifdef FDU_INSTR_COUNT_EN
    output logic [15:0]         instr_count,
`endif
    output logic                addr_fault
);

    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_daddr;
    logic [DATA_W-1:0] r_ir;
    logic              r_addr_fault;
    logic [PC_W-1:0]   w_mem_addr;
    logic              w_in_range;
    logic              w_access;
    logic [2:0]        w_readnum;
    logic              w_unused_dp;

    // Only the low PC_W bits of the datapath result form an address
    assign w_unused_dp = ^datapath_out[DATA_W-1:PC_W];

    // Address mux and range gating of the RAM strobes
    assign w_mem_addr    = addr_sel ? r_pc : r_daddr;
    assign w_in_range    = (w_mem_addr[PC_W-1:MEM_AW] == '0);
    assign w_access      = (mem_cmd == MREAD) || (mem_cmd == MWRITE);
    assign mem.mem_addr  = w_mem_addr;
    assign mem.mem_rd_en = (mem_cmd == MREAD) && w_in_range;
    assign mem.mem_wr_en = (mem_cmd == MWRITE) && w_in_range;

    // PC, data-address, IR and sticky fault flag; reset overrides every strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= '0;
            r_daddr      <= '0;
            r_ir         <= '0;
            r_addr_fault <= 1'b0;
        end else begin
            if (load_pc) begin
                r_pc <= reset_pc ? '0 : r_pc + PC_W'(1);
            end
            if (load_ir) begin
                r_ir <= mem.mdata;
            end
            if (load_addr) begin
                r_daddr <= datapath_out[PC_W-1:0];
            end
            if (w_access && !w_in_range) begin
                r_addr_fault <= 1'b1;
            end
        end
    end

`ifdef FDU_INSTR_COUNT_EN
    logic [15:0] r_instr_count;

    // Count of instruction captures, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (load_ir) begin
            r_instr_count <= r_instr_count + 16'(1);
        end
    end

    assign instr_count = r_instr_count;
`endif

    instr_decoder #(
        .DATA_W (DATA_W)
    ) u_instr_decoder (
        .i_ir        (r_ir),
        .i_nsel      (nsel),
        .o_opcode_c  (opcode),
        .o_op_c      (op),
        .o_readnum_c (w_readnum),
        .o_shift_c   (shift),
        .o_sximm5_c  (sximm5),
        .o_sximm8_c  (sximm8)
    );

    assign readnum    = w_readnum;
    assign writenum   = w_readnum;
    assign pc         = r_pc;
    assign addr_fault = r_addr_fault;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Randomized self-checking bench for fetch_decode_unit against an arithmetic reference model.
module tb_fetch_decode_unit;

    logic        clk = 1'b0;
    logic        reset, load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0]  mem_cmd;
    logic [2:0]  nsel;
    logic [15:0] datapath_out;
    logic [2:0]  opcode, readnum, writenum;
    logic [1:0]  op, shift;
    logic [15:0] sximm5, sximm8;
    logic [8:0]  pc;
    logic        addr_fault;
`ifdef FDU_INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    // reference model state
    int m_pc, m_daddr, m_ir, m_fault, m_cnt;
    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode_unit_if #(.DATA_W(16), .PC_W(9)) mem_bus ();

    fetch_decode_unit dut (
        .clk          (clk),
        .reset        (reset),
        .load_ir      (load_ir),
        .load_pc      (load_pc),
        .reset_pc     (reset_pc),
        .addr_sel     (addr_sel),
        .load_addr    (load_addr),
        .mem_cmd      (mem_cmd),
        .nsel         (nsel),
        .datapath_out (datapath_out),
        .mem          (mem_bus),
        .opcode       (opcode),
        .op           (op),
        .readnum      (readnum),
        .writenum     (writenum),
        .shift        (shift),
        .sximm5       (sximm5),
        .sximm8       (sximm8),
        .pc           (pc),
`ifdef FDU_INSTR_COUNT_EN
        .instr_count  (instr_count),
`endif
        .addr_fault   (addr_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        int r;
        r = v;
        if (r >= (1 << (bits - 1))) r = r - (1 << bits);
        return r & 32'hFFFF;
    endfunction

    function automatic int exp_regnum(input int ir, input logic [2:0] ns);
        if (ns == 3'b100) return (ir >> 8) & 7;
        if (ns == 3'b010) return (ir >> 5) & 7;
        if (ns == 3'b001) return ir & 7;
        return 0;
    endfunction

    // Compare every DUT output with the model state and the currently driven inputs
    task automatic check_all();
        int addr, opc, sh;
        bit inr;
        addr = addr_sel ? m_pc : m_daddr;
        inr  = (addr < 256);
        opc  = (m_ir >> 13) & 7;
        sh   = (opc == 3 || opc == 4) ? 0 : ((m_ir >> 3) & 3);
        check_eq("pc",         32'(pc),         32'(m_pc));
        check_eq("opcode",     32'(opcode),     32'(opc));
        check_eq("op",         32'(op),         32'((m_ir >> 11) & 3));
        check_eq("shift",      32'(shift),      32'(sh));
        check_eq("sximm5",     32'(sximm5),     32'(sext(m_ir & 32'h1F, 5)));
        check_eq("sximm8",     32'(sximm8),     32'(sext(m_ir & 32'hFF, 8)));
        check_eq("readnum",    32'(readnum),    32'(exp_regnum(m_ir, nsel)));
        check_eq("writenum",   32'(writenum),   32'(exp_regnum(m_ir, nsel)));
        check_eq("mem_addr",   32'(mem_bus.mem_addr), 32'(addr));
        check_eq("mem_rd_en",  32'(mem_bus.mem_rd_en), 32'((mem_cmd == 2'b01) && inr));
        check_eq("mem_wr_en",  32'(mem_bus.mem_wr_en), 32'((mem_cmd == 2'b10) && inr));
        check_eq("addr_fault", 32'(addr_fault), 32'(m_fault));
`ifdef FDU_INSTR_COUNT_EN
        check_eq("instr_count", 32'(instr_count), 32'(m_cnt));
`endif
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge
    task automatic step(input logic rst, input logic lir, input logic lpc, input logic rpc,
                        input logic asel, input logic ladr, input logic [1:0] cmd,
                        input logic [2:0] ns, input logic [15:0] md, input logic [15:0] dp);
        int addr;
        @(negedge clk);
        reset = rst; load_ir = lir; load_pc = lpc; reset_pc = rpc; addr_sel = asel;
        load_addr = ladr; mem_cmd = cmd; nsel = ns; mem_bus.mdata = md; datapath_out = dp;
        #1;
        if (!$isunknown(pc)) check_all();
        @(posedge clk);
        addr = asel ? m_pc : m_daddr;
        if (rst) begin
            m_pc = 0; m_daddr = 0; m_ir = 0; m_fault = 0; m_cnt = 0;
        end else begin
            if ((cmd == 2'b01 || cmd == 2'b10) && addr >= 256) m_fault = 1;
            if (lir) begin
                m_ir  = int'(md);
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (lpc) m_pc = rpc ? 0 : (m_pc + 1) % 512;
            if (ladr) m_daddr = int'(dp) % 512;
        end
        #1;
    endtask

    initial begin
        logic [2:0]  ns_tab [5];
        logic [15:0] dp;
        ns_tab[0] = 3'b100; ns_tab[1] = 3'b010; ns_tab[2] = 3'b001; ns_tab[3] = 3'b000;
        m_pc = 0; m_daddr = 0; m_ir = 0; m_fault = 0; m_cnt = 0;

        // reset with load_pc/reset_pc, then three increments
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 16'h0000, 16'h0000);
        check_eq("tp1_pc_reset", 32'(pc), 32'd0);
        check_eq("tp1_opcode_reset", 32'(opcode), 32'd0);
        check_eq("tp1_fault_reset", 32'(addr_fault), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0);
        check_eq("tp1_pc3", 32'(pc), 32'd3);
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0);

        // fetch from pc=5
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b100, 16'hB160, 16'h0);
        check_eq("tp2_mem_addr", 32'(mem_bus.mem_addr), 32'd5);
        check_eq("tp2_rd_en", 32'(mem_bus.mem_rd_en), 32'd1);
        check_eq("tp2_opcode", 32'(opcode), 32'b101);
        check_eq("tp2_op", 32'(op), 32'b10);
        check_eq("tp2_rn", 32'(readnum), 32'b001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 16'h0, 16'h0);
        check_eq("tp2_rd", 32'(readnum), 32'b011);

        // immediates and LDR shift suppression
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 16'hD2F0, 16'h0);
        check_eq("tp3_opcode", 32'(opcode), 32'b110);
        check_eq("tp3_op", 32'(op), 32'b10);
        check_eq("tp3_sximm8", 32'(sximm8), 32'hFFF0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 16'h6210, 16'h0);
        check_eq("tp3_sximm5", 32'(sximm5), 32'hFFF0);
        check_eq("tp3_shift", 32'(shift), 32'd0);

        // out-of-range data address sets a sticky fault
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 16'h0, 16'h0123);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 16'h0, 16'h0);
        check_eq("tp4_mem_addr", 32'(mem_bus.mem_addr), 32'h123);
        check_eq("tp4_wr_en", 32'(mem_bus.mem_wr_en), 32'd0);
        check_eq("tp4_fault", 32'(addr_fault), 32'd1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 16'h0, 16'h0);
        check_eq("tp4_fault_sticky", 32'(addr_fault), 32'd1);

        // walk pc to 511, then fetch+advance together at the wrap
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0);
        repeat (511) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0);
        check_eq("tp5_pc511", 32'(pc), 32'd511);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 16'hABCD, 16'h0);
        check_eq("tp5_pc_wrap", 32'(pc), 32'd0);
        check_eq("tp5_opcode", 32'(opcode), 32'b101);
        check_eq("tp5_sximm8", 32'(sximm8), 32'hFFCD);

`ifdef FDU_INSTR_COUNT_EN
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h1234, 16'h0);
        check_eq("tp6_count4", 32'(instr_count), 32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h1234, 16'h0);
        check_eq("tp6_count_reset", 32'(instr_count), 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ns_tab[4] = 3'($urandom);
            dp = (($urandom % 4) == 0) ? 16'($urandom) : 16'($urandom % 256);
            step(1'(($urandom % 512) == 0), 1'(($urandom % 4) == 0), 1'($urandom % 2),
                 1'(($urandom % 256) == 0), 1'($urandom % 2), 1'(($urandom % 8) == 0),
                 2'($urandom % 4), ns_tab[$urandom % 5], 16'($urandom), dp);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
Front end of the Simple RISC Machine, directly upstream of the controller FSM.
- Owns the program counter, the data-address register and the instruction register, and drives the address mux to memory.
- Gates memory read/write enables from the FSM's mem_cmd.
- Decodes the IR into the opcode/op fields the FSM consumes, plus register numbers and immediates for the datapath.
- Applies the control strobes the FSM produces: load_ir, load_pc, reset_pc, addr_sel, load_addr, nsel.

Parameters:
DATA_W, 16, instruction/data word width
PC_W, 9, width of PC, data-address register and mem_addr
MEM_AW, 8, implemented memory address bits; addresses with any bit at or above MEM_AW set are out of range

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
load_ir  in  1  capture mdata into IR
load_pc  in  1  update PC
reset_pc  in  1  with load_pc, selects 0 as next PC
addr_sel  in  1  1: mem_addr = PC, 0: mem_addr = data-address register
load_addr  in  1  capture datapath_out[PC_W-1:0] into data-address register
mem_cmd  in  2  00 none, 01 read, 10 write, 11 reserved (treated as none)
nsel  in  3  one-hot register select: 100 Rn, 010 Rd, 001 Rm, 000 → register 0
mdata  in  DATA_W  memory read data (combinational from RAM)
datapath_out  in  DATA_W  datapath result (address source for LDR/STR)
mem_addr  out  PC_W  memory address
mem_rd_en  out  1  read strobe to RAM
mem_wr_en  out  1  write strobe to RAM
opcode  out  3  IR[15:13]
op  out  2  IR[12:11]
readnum  out  3  register selected by nsel
writenum  out  3  same as readnum
shift  out  2  IR[4:3]; forced 00 when opcode is 011 (LDR) or 100 (STR)
sximm5  out  DATA_W  sign-extended IR[4:0]
sximm8  out  DATA_W  sign-extended IR[7:0]
pc  out  PC_W  current PC
addr_fault  out  1  sticky out-of-range access flag

Behaviour:
Reset and clocking:
- Single clock clk; reset is synchronous and active-high.
- On reset: PC=0, data-address register=0, IR=0, addr_fault=0.
- Resulting reset outputs: opcode=000, op=00, shift=00, sximm5=0, sximm8=0, readnum=writenum=000, pc=0. mem_addr, mem_rd_en and mem_wr_en follow their combinational rules from the current inputs.
- Reset has priority over every strobe, including mid-instruction.

PC:
- On load_pc: next PC = reset_pc ? 0 : PC+1, modulo 2^PC_W (511 wraps to 0).
- reset_pc without load_pc has no effect.

IR:
- On load_ir: IR <= mdata, one-cycle latency. Decode outputs change the cycle after the capture edge.

Data-address register:
- On load_addr: register <= datapath_out[PC_W-1:0].

Simultaneous strobes:
- load_ir and load_pc in the same cycle: IR captures data addressed by the old PC; PC then advances.
- All three registers update independently when asserted together.

Memory gating (combinational):
- in_range = (mem_addr[PC_W-1:MEM_AW] == 0).
- mem_rd_en = (mem_cmd==01) & in_range.
- mem_wr_en = (mem_cmd==10) & in_range.

Fault flag:
- addr_fault sets on any clock edge where mem_cmd is 01 or 10 and in_range is 0.
- Cleared only by reset.

Decode (combinational from IR):
- nsel encodings other than one-hot or 000 yield readnum=000.

Optional Feature:
Macro FDU_INSTR_COUNT_EN.
- Defined: adds output instr_count, 16 bits. Resets to 0, increments on every load_ir edge, wraps at 0xFFFF to 0. Gives a performance/trace hook.
- Undefined: port absent, no counter logic.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package rsm_pkg holds: mem_cmd encodings (MNONE=00, MREAD=01, MWRITE=10), opcode constants (MOV=110, ALU=101, LDR=011, STR=100, HALT=111), nsel one-hot constants and the DATA_W/PC_W defaults. The FSM and datapath reuse it.
- One natural sub-module: instr_decoder, the purely combinational IR → fields/immediates/readnum logic.
- PC, data-address register, IR and fault flag stay in the top.

Test Plan:
1. Reset sequence: reset=1 for 1 cycle with load_pc=1, reset_pc=1 → pc=0, IR=0, addr_fault=0. Then 3 cycles of load_pc=1, reset_pc=0 → pc=3.
2. Fetch: addr_sel=1, mem_cmd=01, pc=5, mdata=16'hB160, load_ir=1 for one edge → mem_addr=5, mem_rd_en=1. Next cycle opcode=101, op=10, nsel=100 gives readnum=001, nsel=010 gives readnum=011.
3. Immediates: IR=16'hD2F0 → opcode=110, op=10, sximm8=16'hFFF0. IR=16'h6210 (LDR, imm5=10000) → sximm5=16'hFFF0, shift=00.
4. Data address: datapath_out=16'h0123, load_addr=1, then addr_sel=0, mem_cmd=10 → mem_addr=9'h123, mem_wr_en=0, addr_fault=1 after the edge; stays 1 until reset.
5. Wrap and simultaneous strobes: pc=511, load_pc=1 and load_ir=1 together → IR holds the word at 511 (out of range, RAM data as driven), pc=0.
6. FDU_INSTR_COUNT_EN build: 4 load_ir pulses → instr_count=4. Reset mid-sequence → instr_count=0 on the next edge.
